bus_timer: RTL

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_pkg.sv | 12 +
 rtl/bus_timer_tick_gen.sv | 22 ++
 rtl/bus_timer.sv | 86 ++++++++
 3 files changed

// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: shared FSM encoding, register offsets, CTRL bit positions and region code
package bus_timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_t;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_LOAD = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int CTRL_EN = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE = 2;
    localparam logic [1:0] REGION_TIMER = 2'b11;
endpackage

// File: rtl/bus_timer_tick_gen.sv
// tick_gen: prescaler that pulses tick on the last clk of every PRESCALE-cycle period
module tick_gen
    import bus_timer_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
    logic [W-1:0] cnt;
    assign tick = enable && cnt == LAST;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counting timer with auto-reload, sticky DONE and registered irq
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int n = 9,
    parameter int PRESCALE = 50000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [n-1:0] ADDR,
    input  logic [n-1:0] DOUT,
    input  logic         W,
    output logic [n-1:0] rdata,
    output logic         irq,
    output logic [1:0]   state_o
);
    state_t state, state_nxt;
    logic [2:0] ctrl;
    logic [n-1:0] load, count, count_nxt, load_nxt;
    logic done, done_nxt, tick, start, stop, en_nxt;
    logic sel, wr, wr_ctrl, wr_load, wr_status;
    logic [1:0] off;
    logic addr_unused;
    assign addr_unused = ^ADDR[n-3:2];
    assign sel = ADDR[n-1:n-2] == REGION_TIMER;
    assign off = ADDR[1:0];
    assign wr = W & sel;
    assign wr_ctrl = wr && off == REG_CTRL;
    assign wr_load = wr && off == REG_LOAD;
    assign wr_status = wr && off == REG_STATUS;
    // start decisions see the values being written on this same edge
    assign en_nxt = wr_ctrl ? DOUT[CTRL_EN] : ctrl[CTRL_EN];
    assign load_nxt = wr_load ? DOUT : load;
    assign stop = wr_ctrl && !DOUT[CTRL_EN];
    assign start = en_nxt && load_nxt != '0 && (state == IDLE || (state == EXPIRED && wr_ctrl));
    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk(clk),
        .resetn(resetn),
        .clear(start),
        .enable(state == RUN),
        .tick(tick)
    );
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt = done;
        if (wr_status && DOUT[0]) done_nxt = 1'b0;
        if (stop) state_nxt = IDLE;
        else if (start) begin
            state_nxt = RUN;
            count_nxt = load_nxt;
        end
        else if (state == EXPIRED && wr_ctrl) state_nxt = IDLE;
        else if (state == IDLE && wr_load) count_nxt = DOUT;
        else if (state == RUN && tick && count > n'(1)) count_nxt = count - 1'b1;
        else if (state == RUN && tick && count == n'(1)) begin
            done_nxt = 1'b1;
            count_nxt = ctrl[CTRL_AUTO] ? load : '0;
            state_nxt = ctrl[CTRL_AUTO] ? RUN : EXPIRED;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl <= '0;
            load <= '0;
            count <= '0;
            done <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= DOUT[2:0];
            if (wr_load) load <= DOUT;
            count <= count_nxt;
            done <= done_nxt;
            irq <= done & ctrl[CTRL_IE];
        end
    end
    assign rdata = !sel ? '0 :
                   off == REG_CTRL ? n'(ctrl) :
                   off == REG_LOAD ? load :
                   off == REG_COUNT ? count : n'(done);
    assign state_o = state;
endmodule
